// File: rtl/shift_accum_if.sv
// Handshake bundle between the shifter stage, shift_accum and its downstream consumer.
// The slave modport is the accumulator's view of the bundle; the master modport is the view of its neighbours.
interface shift_accum_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [7:0]           out_count;
    logic                 out_ovf;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/shift_accum.sv
// Group accumulator behind the shifter stage: sums COUNT beats (or fewer on flush) and holds the total.
// Optional macro SHIFT_ACCUM_SAT_EN clamps the accumulator to all-ones once a group overflows.
//
// state | meaning
// ACCUM | accepting beats, building the group total
// HOLD  | result presented, waiting for out_ready
module shift_accum #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst,
    shift_accum_if.slave    bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [7:0] COUNT_L = 8'(COUNT);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [7:0]           cnt;
    logic                 grp_ovf;

    logic                 beat;
    logic                 close;
    logic [ACC_WIDTH:0]   nxt;
    logic                 nxt_ovf;
    logic [ACC_WIDTH-1:0] acc_upd;
    logic [ACC_WIDTH-1:0] sum_close;
    logic [7:0]           cnt_inc;

    assign bus.in_ready = (state == ACCUM);

    always_comb begin
        beat    = 1'b0;
        close   = 1'b0;
        nxt     = '0;
        nxt_ovf = grp_ovf;
        acc_upd = acc;
        sum_close = acc;
        cnt_inc = cnt + 8'd1;

        beat = bus.in_valid && (state == ACCUM);
        nxt  = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.in_data};
        if (beat) begin
            nxt_ovf = grp_ovf | nxt[ACC_WIDTH];
`ifdef SHIFT_ACCUM_SAT_EN
            acc_upd = nxt_ovf ? {ACC_WIDTH{1'b1}} : nxt[ACC_WIDTH-1:0];
`else
            acc_upd = nxt[ACC_WIDTH-1:0];
`endif
        end
        sum_close = acc_upd;
        close = (beat && (cnt_inc == COUNT_L)) ||
                (bus.flush && (state == ACCUM) && ((cnt != 8'd0) || beat));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            grp_ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        bus.out_sum   <= sum_close;
                        bus.out_count <= beat ? cnt_inc : cnt;
                        bus.out_ovf   <= nxt_ovf;
                        bus.out_valid <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                        grp_ovf       <= 1'b0;
                        state         <= HOLD;
                    end else if (beat) begin
                        acc     <= acc_upd;
                        cnt     <= cnt_inc;
                        grp_ovf <= nxt_ovf;
                    end
                end
                HOLD: begin
                    // result stays frozen until the consumer takes it; flush has no effect here
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_accum.sv
// Directed vector bench for shift_accum; dut_a uses ACC_WIDTH=10, dut_b ACC_WIDTH=9 for the wrap/clamp case.
module tb_shift_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = '0;
    logic       flush     = 1'b0;
    logic       out_ready = 1'b0;

    shift_accum_if #(.WIDTH(8), .ACC_WIDTH(10)) a_if ();
    shift_accum_if #(.WIDTH(8), .ACC_WIDTH(9))  b_if ();

    assign a_if.in_valid  = in_valid;
    assign a_if.in_data   = in_data;
    assign a_if.flush     = flush;
    assign a_if.out_ready = out_ready;
    assign b_if.in_valid  = in_valid;
    assign b_if.in_data   = in_data;
    assign b_if.flush     = flush;
    assign b_if.out_ready = out_ready;

    shift_accum #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    shift_accum #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(9))  dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       r;
        logic       erdy;
        logic       eov;
        int         esum;
        int         ecnt;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic f, input logic r,
                                input logic erdy, input logic eov, input int esum, input int ecnt,
                                input logic eovf);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r;
        t.erdy = erdy; t.eov = eov; t.esum = esum; t.ecnt = ecnt; t.eovf = eovf;
        vecs.push_back(t);
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        in_valid = v; in_data = d; flush = f; out_ready = r;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] x;
        // group 1: 1,2,3,4 back-to-back
        add(1, 8'd1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'd2, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'd3, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'd4, 0, 1, 1, 1, 10, 4, 0);
        add(1, 8'd7, 0, 1, 0, 0, 0, 0, 0);
        // group 2: 7 x4, consumer stalls for 5 cycles
        for (int i = 0; i < 3; i++) add(1, 8'd7, 0, 0, 1, 0, 0, 0, 0);
        add(1, 8'd7, 0, 0, 1, 1, 28, 4, 0);
        for (int i = 0; i < 5; i++) add(1, 8'd7, 0, 0, 0, 1, 28, 4, 0);
        add(0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
        // flush alone, flush when empty, flush with a beat, flush while holding
        add(1, 8'h10, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'h20, 0, 1, 1, 0, 0, 0, 0);
        add(0, 8'd0,  1, 1, 1, 1, 'h30, 2, 0);
        add(0, 8'd0,  0, 1, 0, 0, 0, 0, 0);
        add(0, 8'd0,  1, 1, 1, 0, 0, 0, 0);
        add(0, 8'd0,  0, 1, 1, 0, 0, 0, 0);
        add(1, 8'h10, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'h20, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'h05, 1, 0, 1, 1, 'h35, 3, 0);
        add(0, 8'd0,  1, 0, 0, 1, 'h35, 3, 0);
        add(0, 8'd0,  0, 1, 0, 0, 0, 0, 0);
        // shifter chained upstream: x=3 shifted by sel 0..3
        x = 8'h03;
        for (int s = 0; s < 4; s++)
            add(1, 8'(x << s), 0, 1, 1, (s == 3), (s == 3) ? 45 : 0, (s == 3) ? 4 : 0, 0);
        add(0, 8'd0, 0, 1, 0, 0, 0, 0, 0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_in_ready", int'(a_if.in_ready), 1);
        chk("reset_out_valid", int'(a_if.out_valid), 0);
        chk("reset_out_sum", int'(a_if.out_sum), 0);
        chk("reset_out_count", int'(a_if.out_count), 0);
        chk("reset_out_ovf", int'(a_if.out_ovf), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v; in_data = vecs[i].d; flush = vecs[i].f; out_ready = vecs[i].r;
            chk($sformatf("vec%0d_in_ready", i), int'(a_if.in_ready), int'(vecs[i].erdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), int'(a_if.out_valid), int'(vecs[i].eov));
            if (vecs[i].eov) begin
                chk($sformatf("vec%0d_out_sum", i), int'(a_if.out_sum), vecs[i].esum);
                chk($sformatf("vec%0d_out_count", i), int'(a_if.out_count), vecs[i].ecnt);
                chk($sformatf("vec%0d_out_ovf", i), int'(a_if.out_ovf), int'(vecs[i].eovf));
            end
        end

        // reset in the middle of a group discards it
        step(1, 8'd9, 0, 1);
        step(1, 8'd9, 0, 1);
        rst = 1'b1;
        step(0, 8'd0, 0, 1);
        rst = 1'b0;
        chk("midrst_out_valid", int'(a_if.out_valid), 0);
        chk("midrst_out_sum", int'(a_if.out_sum), 0);
        chk("midrst_out_count", int'(a_if.out_count), 0);
        chk("midrst_in_ready", int'(a_if.in_ready), 1);
        for (int i = 0; i < 3; i++) step(1, 8'd5, 0, 1);
        chk("midrst_no_early", int'(a_if.out_valid), 0);
        step(1, 8'd5, 0, 1);
        chk("after_rst_out_valid", int'(a_if.out_valid), 1);
        chk("after_rst_out_sum", int'(a_if.out_sum), 20);
        chk("after_rst_out_count", int'(a_if.out_count), 4);
        step(0, 8'd0, 0, 1);
        chk("after_rst_release", int'(a_if.out_valid), 0);

        // 0xFF x4 = 1020: fits in 10 bits, overflows 9 bits
        for (int i = 0; i < 4; i++) step(1, 8'hFF, 0, 1);
        chk("ovf10_out_valid", int'(a_if.out_valid), 1);
        chk("ovf10_out_sum", int'(a_if.out_sum), 1020);
        chk("ovf10_out_ovf", int'(a_if.out_ovf), 0);
        chk("ovf9_out_valid", int'(b_if.out_valid), 1);
        chk("ovf9_out_count", int'(b_if.out_count), 4);
`ifdef SHIFT_ACCUM_SAT_EN
        chk("ovf9_out_sum", int'(b_if.out_sum), 511);
`else
        chk("ovf9_out_sum", int'(b_if.out_sum), 508);
`endif
        chk("ovf9_out_ovf", int'(b_if.out_ovf), 1);
        step(0, 8'd0, 0, 1);
        chk("ovf9_release", int'(b_if.out_valid), 0);

        // sticky overflow is cleared for the next group
        step(1, 8'd1, 1, 1);
        chk("ovf9_clear_sum", int'(b_if.out_sum), 1);
        chk("ovf9_clear_ovf", int'(b_if.out_ovf), 0);
        chk("ovf9_clear_count", int'(b_if.out_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
